// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the seq_gen serial pattern transmitter.
// Holds the FSM state encoding, default sizing and the length clamp helper.
package seq_gen_pkg;

   localparam int STATE_W    = 32'd2;
   localparam int MAXLEN_DEF = 32'd16;
   localparam int LW_DEF     = 32'd5;
   localparam int RW_DEF     = 32'd4;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   function automatic int unsigned clamp_len(input int unsigned len_v, input int unsigned max_v);
      if (len_v > max_v) begin
         clamp_len = max_v;
      end else begin
         clamp_len = len_v;
      end
   endfunction

endpackage

// File: rtl/seq_shreg.sv
// Loadable MSB-first shift register; sout always shows the current top bit.
module seq_shreg
   import seq_gen_pkg::*;
#(
   parameter int W = MAXLEN_DEF
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] d,
   output logic         sout
);

   logic [W-1:0] sr_r;

   // Shift register storage: load wins over shift
   always_ff @(posedge clk) begin
      if (clr) begin
         sr_r <= '0;
      end else if (load) begin
         sr_r <= d;
      end else if (shift) begin
         sr_r <= {sr_r[W-2:0], 1'b0};
      end else begin
         sr_r <= sr_r;
      end
   end

   assign sout = sr_r[W-1];

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first with an
// optional repeat count and idle gap between repetitions.
module seq_gen
   import seq_gen_pkg::*;
#(
   parameter int MAXLEN = MAXLEN_DEF,
   parameter int LW     = LW_DEF,
   parameter int RW     = RW_DEF
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              start,
   input  logic [MAXLEN-1:0] pattern,
   input  logic [LW-1:0]     len,
   input  logic [RW-1:0]     reps,
   input  logic [RW-1:0]     gap,
   output logic              x,
   output logic              xvalid,
   output logic              busy,
   output logic              done
);

   localparam logic [LW-1:0] LEN_ONE = LW'(1'b1);
   localparam logic [LW-1:0] LEN_MAX = LW'(MAXLEN);
   localparam logic [RW-1:0] REP_ONE = RW'(1'b1);

   state_t            state_r, state_nx_s;
   logic [MAXLEN-1:0] pat_r, pat_in_s, ld_data_s, sh_d_s;
   logic [LW-1:0]     len_r, len_in_s, shamt_s, idx_r, idx_nx_s;
   logic [RW-1:0]     reps_r, reps_in_s, gap_r, rep_r, rep_nx_s, gcnt_r, gcnt_nx_s;
   logic              capture_s, load_s, shift_s, sout_s;
   logic              x_nx_s, xvalid_nx_s, busy_nx_s, done_nx_s;
   logic              x_r, xvalid_r, busy_r, done_r;

   // Input conditioning: clamp length, map reps=0 to 1, left-align pattern
   always_comb begin
      len_in_s = LW'(clamp_len(32'(len), 32'(MAXLEN)));
      if (reps == {RW{1'b0}}) begin
         reps_in_s = REP_ONE;
      end else begin
         reps_in_s = reps;
      end
      shamt_s  = LEN_MAX - len_in_s;
      pat_in_s = pattern << shamt_s;
   end

   // The register already holds the bit after the one presented on a load
   assign sh_d_s = {ld_data_s[MAXLEN-2:0], 1'b0};

   seq_shreg #(.W(MAXLEN)) u_shreg (
      .clk   (clk),
      .clr   (clr),
      .load  (load_s),
      .shift (shift_s),
      .d     (sh_d_s),
      .sout  (sout_s)
   );

   // Next-state and next-output logic; outputs describe the following cycle
   always_comb begin
      state_nx_s  = state_r;
      idx_nx_s    = idx_r;
      rep_nx_s    = rep_r;
      gcnt_nx_s   = gcnt_r;
      capture_s   = 1'b0;
      load_s      = 1'b0;
      shift_s     = 1'b0;
      ld_data_s   = pat_r;
      x_nx_s      = 1'b0;
      xvalid_nx_s = 1'b0;
      busy_nx_s   = 1'b0;
      done_nx_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               capture_s = 1'b1;
               if (len_in_s != {LW{1'b0}}) begin
                  state_nx_s  = SEND;
                  idx_nx_s    = len_in_s - LEN_ONE;
                  rep_nx_s    = REP_ONE;
                  load_s      = 1'b1;
                  ld_data_s   = pat_in_s;
                  x_nx_s      = pat_in_s[MAXLEN-1];
                  xvalid_nx_s = 1'b1;
                  busy_nx_s   = 1'b1;
               end else begin
                  done_nx_s = 1'b1;
               end
            end else begin
               state_nx_s = IDLE;
            end
         end
         SEND: begin
            if (idx_r != {LW{1'b0}}) begin
               idx_nx_s    = idx_r - LEN_ONE;
               shift_s     = 1'b1;
               x_nx_s      = sout_s;
               xvalid_nx_s = 1'b1;
               busy_nx_s   = 1'b1;
            end else if (rep_r == reps_r) begin
               state_nx_s = IDLE;
               done_nx_s  = 1'b1;
            end else if (gap_r != {RW{1'b0}}) begin
               state_nx_s = GAP;
               gcnt_nx_s  = gap_r;
               busy_nx_s  = 1'b1;
            end else begin
               idx_nx_s    = len_r - LEN_ONE;
               rep_nx_s    = rep_r + REP_ONE;
               load_s      = 1'b1;
               x_nx_s      = pat_r[MAXLEN-1];
               xvalid_nx_s = 1'b1;
               busy_nx_s   = 1'b1;
            end
         end
         GAP: begin
            busy_nx_s = 1'b1;
            if (gcnt_r == REP_ONE) begin
               state_nx_s  = SEND;
               idx_nx_s    = len_r - LEN_ONE;
               rep_nx_s    = rep_r + REP_ONE;
               load_s      = 1'b1;
               x_nx_s      = pat_r[MAXLEN-1];
               xvalid_nx_s = 1'b1;
            end else begin
               gcnt_nx_s = gcnt_r - REP_ONE;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State, counters, captured transfer parameters and registered outputs
   always_ff @(posedge clk) begin
      if (clr) begin
         state_r  <= IDLE;
         idx_r    <= '0;
         rep_r    <= '0;
         gcnt_r   <= '0;
         pat_r    <= '0;
         len_r    <= '0;
         reps_r   <= '0;
         gap_r    <= '0;
         x_r      <= 1'b0;
         xvalid_r <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         state_r  <= state_nx_s;
         idx_r    <= idx_nx_s;
         rep_r    <= rep_nx_s;
         gcnt_r   <= gcnt_nx_s;
         x_r      <= x_nx_s;
         xvalid_r <= xvalid_nx_s;
         busy_r   <= busy_nx_s;
         done_r   <= done_nx_s;
         if (capture_s) begin
            pat_r  <= pat_in_s;
            len_r  <= len_in_s;
            reps_r <= reps_in_s;
            gap_r  <= gap;
         end else begin
            pat_r  <= pat_r;
            len_r  <= len_r;
            reps_r <= reps_r;
            gap_r  <= gap_r;
         end
      end
   end

   assign x      = x_r;
   assign xvalid = xvalid_r;
   assign busy   = busy_r;
   assign done   = done_r;

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: a transaction-level model expands every accepted
// start into per-cycle expected outputs; a monitor compares them every cycle.
module tb_seq_gen;

   logic        clk = 1'b0;
   logic        clr, start;
   logic [15:0] pattern;
   logic [4:0]  len;
   logic [3:0]  reps, gap;
   logic        x, xvalid, busy, done;

   seq_gen dut (
      .clk     (clk),
      .clr     (clr),
      .start   (start),
      .pattern (pattern),
      .len     (len),
      .reps    (reps),
      .gap     (gap),
      .x       (x),
      .xvalid  (xvalid),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   // o = {x, xvalid, busy, done} expected in interval ts
   typedef struct {
      int         ts;
      logic [3:0] o;
   } rec_t;

   rec_t exp_q[$];
   int   t        = 0;
   int   b_last   = -1;
   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   bit   mon_en   = 1'b0;

   // interval counter: t = number of rising edges seen so far
   always @(posedge clk) t <= t + 1;

   function automatic void push(input int ts, input logic [3:0] o);
      rec_t r;
      r.ts = ts;
      r.o  = o;
      exp_q.push_back(r);
   endfunction

   // Reference model: inputs set now are sampled at edge e = t+1
   task automatic model_issue(input bit st, input bit c, input logic [15:0] p,
                              input int l, input int r, input int g);
      int e;
      int nbits, nreps, ts;
      e = t + 1;
      if (c) begin
         while (exp_q.size() > 0 && exp_q[$].ts >= e) void'(exp_q.pop_back());
         if (b_last > e - 1) b_last = e - 1;
      end else if (st && t > b_last) begin
         nbits = (l > 16) ? 16 : l;
         nreps = (r == 0) ? 1 : r;
         ts    = e;
         if (nbits == 0) begin
            push(e, 4'b0001);
         end else begin
            for (int k = 0; k < nreps; k++) begin
               for (int i = nbits - 1; i >= 0; i--) begin
                  push(ts, {p[i], 3'b110});
                  ts++;
               end
               if (k < nreps - 1) begin
                  for (int j = 0; j < g; j++) begin
                     push(ts, 4'b0010);
                     ts++;
                  end
               end
            end
            push(ts, 4'b0001);
            b_last = ts - 1;
         end
      end
   endtask

   task automatic step(input bit st, input bit c, input logic [15:0] p,
                       input logic [4:0] l, input logic [3:0] r, input logic [3:0] g);
      start   = st;
      clr     = c;
      pattern = p;
      len     = l;
      reps    = r;
      gap     = g;
      model_issue(st, c, p, int'(l), int'(r), int'(g));
      @(posedge clk);
      #1;
      start = 1'b0;
      clr   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: every cycle, compare outputs with the scheduled record or idle
   always @(negedge clk) begin : mon
      logic [3:0] e_o;
      logic [3:0] a_o;
      if (mon_en) begin
         e_o = 4'b0000;
         if (exp_q.size() > 0 && exp_q[0].ts <= t) begin
            e_o = exp_q[0].o;
            void'(exp_q.pop_front());
         end
         a_o = {x, xvalid, busy, done};
         chk_cnt++;
         if (a_o === e_o) begin
            pass_cnt++;
         end else begin
            $display("FAIL outputs t=%0d x/xvalid/busy/done got %b expected %b", t, a_o, e_o);
         end
      end
   end

   initial begin : drive
      bit st_b, c_b;
      int n;
      clr = 1'b1; start = 1'b0; pattern = 16'h0; len = 5'd0; reps = 4'd0; gap = 4'd0;
      @(posedge clk);
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      idle(2);
      clr = 1'b0;

      step(1'b1, 1'b0, 16'h0003, 5'd4, 4'd1, 4'd0);    // basic 0,0,1,1
      idle(6);
      step(1'b1, 1'b0, 16'h0005, 5'd3, 4'd2, 4'd2);    // repeat with gap
      idle(10);
      step(1'b1, 1'b0, 16'hFFFF, 5'd0, 4'd3, 4'd1);    // len 0
      idle(3);
      step(1'b1, 1'b0, 16'hA5C3, 5'd31, 4'd1, 4'd0);   // len clamp
      idle(18);
      step(1'b1, 1'b0, 16'h0006, 5'd3, 4'd0, 4'd1);    // reps 0
      idle(5);

      step(1'b1, 1'b0, 16'h00F0, 5'd8, 4'd1, 4'd0);    // ignored start while busy
      idle(2);
      step(1'b1, 1'b0, 16'hFFFF, 5'd8, 4'd2, 4'd0);
      n = 0;
      while (t != b_last + 1 && n < 100) begin
         idle(1);
         n++;
      end
      if (n >= 100) begin
         chk_cnt++;
         $display("FAIL done_wait timeout t=%0d expected done interval %0d", t, b_last + 1);
      end
      step(1'b1, 1'b0, 16'h0009, 5'd4, 4'd2, 4'd1);    // start in done cycle
      idle(14);

      step(1'b1, 1'b0, 16'h000F, 5'd4, 4'd1, 4'd0);    // clr during 2nd bit
      idle(1);
      step(1'b0, 1'b1, 16'h0000, 5'd4, 4'd1, 4'd0);
      idle(2);
      step(1'b1, 1'b1, 16'hFFFF, 5'd4, 4'd1, 4'd0);    // clr with start
      idle(3);

      for (int i = 0; i < 300; i++) begin
         st_b = ($urandom_range(0, 2) == 0);
         c_b  = ($urandom_range(0, 49) == 0);
         step(st_b, c_b, 16'($urandom), 5'($urandom_range(0, 20)),
              4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
      end

      n = 0;
      while (exp_q.size() > 0 && n < 400) begin
         idle(1);
         n++;
      end
      if (n >= 400) begin
         chk_cnt++;
         $display("FAIL drain timeout pending records %0d expected 0", exp_q.size());
      end
      idle(3);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial pattern transmitter: the source end of the single-bit `x` stream that feeds our sequence-detector FSMs. It captures a programmable bit pattern on `start` and shifts it out MSB-first, one bit per clock, with an optional repeat count and idle gap between repetitions. It replaces hand-written `x` stimulus and sits upstream of any detector taking `(x, clk, clr)`.

## Interface
- `MAXLEN`, 16: maximum pattern length in bits. Must satisfy `MAXLEN <= 2**LW - 1`.
- `LW`, 5: width of `len`.
- `RW`, 4: width of `reps` and `gap`.

Ports:
- `clk`, input, 1: clock; all state changes on its rising edge.
- `clr`, input, 1: reset; synchronous, active-high.
- `start`, input, 1: request transmission; sampled only while `busy=0`.
- `pattern`, input, MAXLEN: bits to send; `pattern[len-1]` goes out first, `pattern[0]` last.
- `len`, input, LW: number of bits per repetition; values above `MAXLEN` are clamped to `MAXLEN`.
- `reps`, input, RW: number of repetitions; 0 is treated as 1.
- `gap`, input, RW: idle cycles inserted between repetitions (not after the last one).
- `x`, output, 1: serial data; 0 whenever not sending.
- `xvalid`, output, 1: high in every cycle where `x` carries a pattern bit.
- `busy`, output, 1: high from the first bit through the last bit, including gap cycles.
- `done`, output, 1: one-cycle pulse after the last bit.

## Operation
- States: IDLE, SEND, GAP.
- On reset and in IDLE: `x=0`, `xvalid=0`, `busy=0`. `done` is 0 except for its pulse.
- IDLE with `start=1`:
  - Capture `pattern`, clamped `len`, effective `reps`, and `gap` into internal registers. Later input changes have no effect on the transfer in progress.
  - If `len != 0`: go to SEND with bit index `len-1` and repetition counter 1.
  - If `len == 0`: stay in IDLE and pulse `done` in the next cycle. `busy` never asserts.
- SEND: drive `x` = captured `pattern[idx]`, `xvalid=1`, `busy=1`, then decrement `idx`. When `idx==0`:
  - If this was the last repetition: go to IDLE and pulse `done`.
  - Else if `gap != 0`: go to GAP with the gap counter set to `gap`.
  - Else: reload `idx=len-1`, increment the repetition counter, and stay in SEND. Repetitions are back-to-back with no bubble.
- GAP: `x=0`, `xvalid=0`, `busy=1`. Decrement the gap counter; at 1, reload `idx` and the repetition counter and return to SEND.
- `start` is ignored while `busy=1`. `start` is accepted in the cycle `done` is high, because `busy` is already 0.
- `clr` has priority over everything, including `start` in the same cycle. It forces IDLE and zeroes all outputs and counters at the next edge. A transfer interrupted by `clr` produces no `done`.

## Timing
- `start` sampled high at edge N: the first bit is on `x` with `xvalid=1` in the cycle after edge N (1-cycle latency).
- Pattern bits occupy cycles N+1 .. N+len; each bit holds for exactly one clock.
- Total `busy` duration is `reps*len + (reps-1)*gap` cycles.
- `done` is high in the single cycle immediately after the last bit. `busy=0` in that cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `seq_gen_pkg` holds:
  - the state enum (IDLE/SEND/GAP) and its encoding width;
  - the default `MAXLEN`/`LW`/`RW` constants;
  - a `clamp_len` function.
- One sub-module fits naturally: `seq_shreg`, a loadable MAXLEN-bit shift register with `load`/`shift` enables and an MSB-first serial output. The top level holds the FSM, the repetition counter and the gap counter.

## Test plan
- Basic: `pattern=16'b0011`, `len=4`, `reps=1`, `gap=0`, start at edge N → `x`=0,0,1,1 in cycles N+1..N+4 with `xvalid=1`; `done=1` at N+5 only; `busy` high N+1..N+4. Feeding `x` to the detector yields `z` on the expected bit.
- Repeat with gap: `pattern=0b101`, `len=3`, `reps=2`, `gap=2` → `x`=1,0,1,0,0,1,0,1 over 8 cycles; `xvalid`=1,1,1,0,0,1,1,1; `done` in cycle 9.
- Boundaries, part 1: `len=0` → `done` pulses at N+1 and `busy` stays 0. `len=31` with `MAXLEN=16` → exactly 16 bits sent, `pattern[15]` first.
- Boundaries, part 2: `reps=0` → behaves as a single repetition.
- Ignored start: pulse `start` with a different pattern while `busy=1` → the current stream is unchanged. Assert `start` during the `done` cycle → the new stream begins on the next cycle.
- Reset mid-operation: `clr=1` during the 2nd bit of a 4-bit send → `x=0`, `xvalid=0`, `busy=0` the next cycle, and no `done` pulse. `clr` and `start` together → remains IDLE.
